dmem_responder: RTL

- Memory-side responder for the pipeline's data-memory port.
- Takes one read or write request at a time from the MEM stage and holds it for a fixed number of wait states.
- Commits writes and returns read data with a one-cycle response pulse.
- Drives a stall to the pipeline while a request is outstanding, which makes data-memory latency a real multi-cycle access.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Responder FSM: idle / counting wait states / one-cycle response
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word index of a byte address (drops the byte offset)
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [BE_W-1:0]                be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Byte-lane write; only enabled lanes change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read of the addressed word (old data on a same-cycle write)
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, then
// commits the write / returns the read word with a one-cycle response pulse.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;

  // Request fields latched at accept
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [BE_W-1:0]   be_q;

  // Response-side registers
  logic              resp_err_q;
  logic              resp_zero_q;
  logic [31:0]       rdata_hold_q;

  // Request as seen by the array: live inputs while idle (needed when there
  // are no wait states and the access happens on the accept edge), latched
  // fields otherwise.
  logic              eff_we;
  logic [31:0]       eff_addr;
  logic [31:0]       eff_wdata;
  logic [BE_W-1:0]   eff_be;
  logic [29:0]       eff_widx;
  logic              eff_err;
  logic              enter_resp;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [31:0]       arr_rdata;
  logic [31:0]       rdata_now;

  // Select live or latched request fields and derive the address check
  always_comb begin
    eff_we    = req_we;
    eff_addr  = req_addr;
    eff_wdata = req_wdata;
    eff_be    = req_be;
    if (state_q != ST_IDLE) begin
      eff_we    = we_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      eff_be    = be_q;
    end
    eff_widx = word_index(eff_addr);
    eff_err  = (eff_addr[1:0] != 2'b00) || (eff_widx >= 30'(DEPTH_WORDS));
    arr_idx  = eff_widx[IDX_W-1:0];
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs and array write strobe; the write lands on the edge
  // entering RESP and is suppressed while reset is held
  always_comb begin
    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    arr_we     = enter_resp && eff_we && !eff_err && rst;
    req_ready  = (state_q == ST_IDLE);
    stall      = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);
    resp_valid = (state_q == ST_RESP);
    rdata_now  = resp_zero_q ? 32'd0 : arr_rdata;
    resp_rdata = (state_q == ST_RESP) ? rdata_now : rdata_hold_q;
    resp_err   = resp_err_q;
  end

  // FSM state, counter and request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Response flags captured entering RESP; read data held after RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_err_q   <= 1'b0;
      resp_zero_q  <= 1'b0;
      rdata_hold_q <= 32'd0;
    end else begin
      if (enter_resp) begin
        resp_err_q  <= eff_err;
        resp_zero_q <= eff_err || eff_we;
      end
      if (state_q == ST_RESP) begin
        rdata_hold_q <= rdata_now;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (eff_be),
    .idx   (arr_idx),
    .wdata (eff_wdata),
    .rdata (arr_rdata)
  );

endmodule
